// File: rtl/mic1_pkg.sv
// Shared MIC-1 widths, default memory size and byte extension helpers.
// No logic of its own; imported by the datapath memory interface files.
// Word-oriented definitions used by both port channels and the MBR path.
package mic1_pkg;

  localparam int WORD_W            = 32;
  localparam int BYTE_W            = 8;
  localparam int DEFAULT_MEM_WORDS = 512;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BYTE_W-1:0] byte_t;

  // MBR as a signed operand (e.g. BIPUSH immediates, branch offsets)
  function automatic word_t sext_byte(input byte_t b);
    return {{(WORD_W-BYTE_W){b[BYTE_W-1]}}, b};
  endfunction

  // MBR as an unsigned operand (e.g. opcodes, local variable indices)
  function automatic word_t zext_byte(input byte_t b);
    return {{(WORD_W-BYTE_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/mem_req_chan.sv
// One memory port request channel: captures a request and its address/data at the issue edge.
// Latency: strobe is high for exactly the one cycle after the issue edge.
// No backpressure: memory accepts every strobe, so a new request may issue every cycle.
module mem_req_chan
  import mic1_pkg::*;
#(
  parameter int ADDR_W = WORD_W,
  parameter int DAT_W  = WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DAT_W-1:0]  i_wdata,
  output logic              o_ren,
  output logic              o_wen,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DAT_W-1:0]  o_wdata
);

  logic              r_pend;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DAT_W-1:0]  r_wdata;

  // Pending flag lives one cycle; address/data are held so the live registers may move on
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_pend <= i_req;
      if (i_req) begin
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
    end
  end

  assign o_ren   = r_pend & ~r_we;
  assign o_wen   = r_pend &  r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/mem_interface.sv
// MIC-1 memory interface: owns MAR/MDR/PC/MBR and drives port A (word) and port B (byte fetch).
// Latency: strobe in the cycle after rd/wr/fetch; MDR/MBR data visible two cycles after issue.
// No backpressure: one request per port per cycle, pipelined without stall; conflicts flag proto_err.
module mem_interface
  import mic1_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 32'h0,
  parameter int                MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] c_bus,
  input  logic              load_mar,
  input  logic              load_mdr,
  input  logic              load_pc,
  input  logic              rd,
  input  logic              wr,
  input  logic              fetch,
  output logic [WORD_W-1:0] mdr_out,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] mbr_s,
  output logic [WORD_W-1:0] mbr_u,
  output logic              wen_A,
  output logic              ren_A,
  output logic              ren_B,
  output logic [WORD_W-1:0] addr_A,
  output logic [WORD_W-1:0] addr_B,
  output logic [WORD_W-1:0] wdata_A,
  input  logic [WORD_W-1:0] rdata_A,
  input  logic [BYTE_W-1:0] rdata_B,
  output logic              proto_err
);

  // MAR is a word address, PC a byte address into the same memory
  localparam word_t MAR_LIMIT = word_t'(MEM_WORDS);
  localparam word_t PC_LIMIT  = word_t'(4 * MEM_WORDS);

  logic [WORD_W-1:0] r_mar;
  logic [WORD_W-1:0] r_mdr;
  logic [WORD_W-1:0] r_pc;
  logic [BYTE_W-1:0] r_mbr;
  logic              r_proto_err;

  // Values the registers hold after this edge; requests sample these so a same-cycle load is honoured
  logic [WORD_W-1:0] w_mar_nxt;
  logic [WORD_W-1:0] w_pc_nxt;
  logic [WORD_W-1:0] w_wdata_nxt;

  logic              w_a_req;
  logic              w_a_ren;
  logic              w_a_wen;
  logic              w_b_ren;
  logic              w_b_wen;
  logic [0:0]        w_b_wdata;
  logic              w_b_unused;
  logic              w_err_rdwr;
  logic              w_err_mdr;
  logic              w_err_mar;
  logic              w_err_pc;

  assign w_mar_nxt   = load_mar ? c_bus : r_mar;
  assign w_pc_nxt    = load_pc  ? c_bus : r_pc;
  assign w_wdata_nxt = load_mdr ? c_bus : r_mdr;

  // rd and wr together collapse to a single write on port A
  assign w_a_req = rd | wr;

  mem_req_chan #(
    .ADDR_W (WORD_W),
    .DAT_W  (WORD_W)
  ) u_chan_a (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_a_req),
    .i_we    (wr),
    .i_addr  (w_mar_nxt),
    .i_wdata (w_wdata_nxt),
    .o_ren   (w_a_ren),
    .o_wen   (w_a_wen),
    .o_addr  (addr_A),
    .o_wdata (wdata_A)
  );

  mem_req_chan #(
    .ADDR_W (WORD_W),
    .DAT_W  (1)
  ) u_chan_b (
    .clk     (clk),
    .rst     (rst),
    .i_req   (fetch),
    .i_we    (1'b0),
    .i_addr  (w_pc_nxt),
    .i_wdata (1'b0),
    .o_ren   (w_b_ren),
    .o_wen   (w_b_wen),
    .o_addr  (addr_B),
    .o_wdata (w_b_wdata)
  );

  // Port B is read-only; its write-side outputs are constant and deliberately dropped
  assign w_b_unused = w_b_wen ^ w_b_wdata[0];

  assign ren_A = w_a_ren;
  assign wen_A = w_a_wen;
  assign ren_B = w_b_ren;

  assign w_err_rdwr = rd & wr;
  assign w_err_mdr  = w_a_ren & load_mdr;
  assign w_err_mar  = w_a_req & (w_mar_nxt >= MAR_LIMIT);
  assign w_err_pc   = fetch & (w_pc_nxt >= PC_LIMIT);

  // MAR and PC: plain C-bus loads; an in-flight fetch keeps its own held address
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mar <= '0;
      r_pc  <= RESET_PC;
    end else begin
      r_mar <= w_mar_nxt;
      r_pc  <= w_pc_nxt;
    end
  end

  // MDR: read return has priority over a C-bus load at the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mdr <= '0;
    end else if (w_a_ren) begin
      r_mdr <= rdata_A;
    end else if (load_mdr) begin
      r_mdr <= c_bus;
    end
  end

  // MBR: captures the fetched byte at the end of the strobe cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mbr <= '0;
    end else if (w_b_ren) begin
      r_mbr <= rdata_B;
    end
  end

  // Sticky protocol/range error, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_proto_err <= 1'b0;
    end else if (w_err_rdwr | w_err_mdr | w_err_mar | w_err_pc) begin
      r_proto_err <= 1'b1;
    end
  end

  assign mdr_out   = r_mdr;
  assign pc_out    = r_pc;
  assign mbr_s     = sext_byte(r_mbr);
  assign mbr_u     = zext_byte(r_mbr);
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface with a little-endian main memory model on both ports.
// Memory answers strobes at the negedge of the strobe cycle.
// Inputs change 1 time unit after posedge; outputs are checked at that same point.
module tb_mem_interface;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0010;

  logic        clk;
  logic        rst;
  logic [31:0] c_bus;
  logic        load_mar;
  logic        load_mdr;
  logic        load_pc;
  logic        rd;
  logic        wr;
  logic        fetch;
  logic [31:0] mdr_out;
  logic [31:0] pc_out;
  logic [31:0] mbr_s;
  logic [31:0] mbr_u;
  logic        wen_A;
  logic        ren_A;
  logic        ren_B;
  logic [31:0] addr_A;
  logic [31:0] addr_B;
  logic [31:0] wdata_A;
  logic [31:0] rdata_A;
  logic [7:0]  rdata_B;
  logic        proto_err;

  int n_chk;
  int n_err;

  logic [31:0] mem [512];
  logic [31:0] w_fword;

  mem_interface #(
    .RESET_PC  (TB_RESET_PC),
    .MEM_WORDS (512)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .c_bus     (c_bus),
    .load_mar  (load_mar),
    .load_mdr  (load_mdr),
    .load_pc   (load_pc),
    .rd        (rd),
    .wr        (wr),
    .fetch     (fetch),
    .mdr_out   (mdr_out),
    .pc_out    (pc_out),
    .mbr_s     (mbr_s),
    .mbr_u     (mbr_u),
    .wen_A     (wen_A),
    .ren_A     (ren_A),
    .ren_B     (ren_B),
    .addr_A    (addr_A),
    .addr_B    (addr_B),
    .wdata_A   (wdata_A),
    .rdata_A   (rdata_A),
    .rdata_B   (rdata_B),
    .proto_err (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign w_fword = mem[addr_B[10:2]];

  // Memory model: (re)loaded while reset is held, otherwise serves strobes on the negedge
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h1111_1111;
      mem[1] <= 32'hAABB_CCDD;
      mem[2] <= 32'h3333_3333;
      mem[5] <= 32'hDEAD_BEEF;
      mem[9] <= 32'h9999_9999;
    end else begin
      if (ren_A) rdata_A <= mem[addr_A[8:0]];
      if (wen_A) mem[addr_A[8:0]] <= wdata_A;
      if (ren_B) rdata_B <= w_fword[8*addr_B[1:0] +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_bus    = 32'h0;
    load_mar = 1'b0;
    load_mdr = 1'b0;
    load_pc  = 1'b0;
    rd       = 1'b0;
    wr       = 1'b0;
    fetch    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rdata_A = 32'h0;
    rdata_B = 8'h0;
    #1;

    // Reset state
    do_reset();
    chk("rst_renA", {31'b0, ren_A}, 32'd0);
    chk("rst_wenA", {31'b0, wen_A}, 32'd0);
    chk("rst_renB", {31'b0, ren_B}, 32'd0);
    chk("rst_pc",   pc_out, TB_RESET_PC);
    chk("rst_mdr",  mdr_out, 32'h0);
    chk("rst_mbr",  mbr_u, 32'h0);
    chk("rst_err",  {31'b0, proto_err}, 32'd0);
    step();

    // Single read with same-cycle MAR load
    load_mar = 1'b1; c_bus = 32'd5; rd = 1'b1;
    step();
    idle();
    chk("rd_renA", {31'b0, ren_A}, 32'd1);
    chk("rd_wenA", {31'b0, wen_A}, 32'd0);
    chk("rd_addr", addr_A, 32'd5);
    step();
    chk("rd_mdr",  mdr_out, 32'hDEAD_BEEF);
    chk("rd_done", {31'b0, ren_A}, 32'd0);

    // Write uses held address/data while MAR changes underneath
    load_mdr = 1'b1; c_bus = 32'h1234_5678;
    step();
    idle();
    load_mar = 1'b1; c_bus = 32'd7; wr = 1'b1;
    step();
    idle();
    load_mar = 1'b1; c_bus = 32'd9;
    chk("wr_wenA",  {31'b0, wen_A}, 32'd1);
    chk("wr_renA",  {31'b0, ren_A}, 32'd0);
    chk("wr_addr",  addr_A, 32'd7);
    chk("wr_wdata", wdata_A, 32'h1234_5678);
    step();
    idle();
    chk("wr_mem7", mem[7], 32'h1234_5678);
    chk("wr_mem9", mem[9], 32'h9999_9999);
    chk("wr_mdr",  mdr_out, 32'h1234_5678);

    // Fetch keeps its held PC while PC is reloaded
    load_pc = 1'b1; c_bus = 32'd6;
    step();
    idle();
    fetch = 1'b1;
    step();
    idle();
    load_pc = 1'b1; c_bus = 32'd7;
    chk("f_renB", {31'b0, ren_B}, 32'd1);
    chk("f_addr", addr_B, 32'd6);
    step();
    idle();
    chk("f_mbru", mbr_u, 32'h0000_00BB);
    chk("f_mbrs", mbr_s, 32'hFFFF_FFBB);
    chk("f_pc",   pc_out, 32'd7);
    chk("f_done", {31'b0, ren_B}, 32'd0);

    // Back-to-back reads at MAR = 0, 1, 2
    load_mar = 1'b1; c_bus = 32'd0; rd = 1'b1;
    step();
    c_bus = 32'd1;
    chk("p_ren0", {31'b0, ren_A}, 32'd1);
    chk("p_adr0", addr_A, 32'd0);
    step();
    c_bus = 32'd2;
    chk("p_ren1", {31'b0, ren_A}, 32'd1);
    chk("p_adr1", addr_A, 32'd1);
    chk("p_mdr0", mdr_out, 32'h1111_1111);
    step();
    idle();
    chk("p_ren2", {31'b0, ren_A}, 32'd1);
    chk("p_adr2", addr_A, 32'd2);
    chk("p_mdr1", mdr_out, 32'hAABB_CCDD);
    step();
    chk("p_ren3", {31'b0, ren_A}, 32'd0);
    chk("p_mdr2", mdr_out, 32'h3333_3333);
    chk("p_err",  {31'b0, proto_err}, 32'd0);

    // Highest legal word address does not flag
    load_mar = 1'b1; c_bus = 32'd511; rd = 1'b1;
    step();
    idle();
    chk("b_renA", {31'b0, ren_A}, 32'd1);
    chk("b_err",  {31'b0, proto_err}, 32'd0);
    step();

    // rd and wr together: write only, error flagged
    load_mar = 1'b1; c_bus = 32'd3; rd = 1'b1; wr = 1'b1;
    step();
    idle();
    chk("rw_wenA", {31'b0, wen_A}, 32'd1);
    chk("rw_renA", {31'b0, ren_A}, 32'd0);
    chk("rw_err",  {31'b0, proto_err}, 32'd1);
    do_reset();
    chk("rw_clr",  {31'b0, proto_err}, 32'd0);

    // Out-of-range MAR still strobes but flags
    load_mar = 1'b1; c_bus = 32'd600; rd = 1'b1;
    step();
    idle();
    chk("or_renA", {31'b0, ren_A}, 32'd1);
    chk("or_addr", addr_A, 32'd600);
    chk("or_err",  {31'b0, proto_err}, 32'd1);
    do_reset();

    // Out-of-range PC fetch flags
    load_pc = 1'b1; c_bus = 32'd2048; fetch = 1'b1;
    step();
    idle();
    chk("opc_renB", {31'b0, ren_B}, 32'd1);
    chk("opc_err",  {31'b0, proto_err}, 32'd1);
    do_reset();

    // Read return collides with load_mdr: memory data wins
    load_mar = 1'b1; c_bus = 32'd5; rd = 1'b1;
    step();
    idle();
    load_mdr = 1'b1; c_bus = 32'hCAFE_F00D;
    step();
    idle();
    chk("cm_mdr", mdr_out, 32'hDEAD_BEEF);
    chk("cm_err", {31'b0, proto_err}, 32'd1);
    do_reset();

    // Reset together with rd: request dropped
    load_mar = 1'b1; c_bus = 32'd5; rd = 1'b1; rst = 1'b1;
    step();
    idle();
    rst = 1'b0;
    chk("ra_renA", {31'b0, ren_A}, 32'd0);
    chk("ra_mdr",  mdr_out, 32'h0);
    step();
    chk("ra_mdr2", mdr_out, 32'h0);

    // Reset during the strobe cycle: read discarded
    load_mar = 1'b1; c_bus = 32'd5; rd = 1'b1;
    step();
    idle();
    chk("rb_renA", {31'b0, ren_A}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rb_renA2", {31'b0, ren_A}, 32'd0);
    chk("rb_mdr",   mdr_out, 32'h0);
    step();
    chk("rb_mdr2",  mdr_out, 32'h0);
    chk("rb_err",   {31'b0, proto_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
